ex: RTL

EX -- requirements
Module: ex

---
 rtl/ex.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/ex.sv
// EX stage: ALU (logic/shift/move/arith) plus an optional iterative HI/LO multiplier.
// Latency: ALU results are combinational (0 cycles); MULT/MULTU holds stallreq_o for 33 cycles.
// Backpressure: stallreq_o asks the pipeline to hold IF/ID/EX; flush_i aborts an in-flight multiply.
//
// Optional feature: define EX_MULT_EN to build the multiply FSM, counter and HI/LO registers.
// Without it MULT/MULTU behave as NOP, stallreq_o is 0 and HI/LO (and MFHI/MFLO) read as 0.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   aluop_i, alusel_i           operation code and result class from decode
//   reg1_i, reg2_i              operands (shift amount is reg1_i[4:0], value shifted is reg2_i)
//   wd_i, wreg_i                destination register and write enable
//   flush_i                     abort an in-flight multiply / block a multiply start
//   wd_o, wreg_o, wdata_o       write-back request (also forwarded to decode)
//   stallreq_o, ovf_o           pipeline stall request, signed ADD/SUB overflow
//   hi_o, lo_o                  current HI/LO contents
module ex (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        flush_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        ovf_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_AND   = 8'h24;
    localparam logic [7:0] OP_OR    = 8'h25;
    localparam logic [7:0] OP_XOR   = 8'h26;
    localparam logic [7:0] OP_NOR   = 8'h27;
    localparam logic [7:0] OP_SLL   = 8'h7C;
    localparam logic [7:0] OP_SRL   = 8'h02;
    localparam logic [7:0] OP_SRA   = 8'h03;
    localparam logic [7:0] OP_ADD   = 8'h20;
    localparam logic [7:0] OP_ADDU  = 8'h21;
    localparam logic [7:0] OP_SUB   = 8'h22;
    localparam logic [7:0] OP_SUBU  = 8'h23;
    localparam logic [7:0] OP_SLT   = 8'h2A;
    localparam logic [7:0] OP_SLTU  = 8'h2B;
    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MFLO  = 8'h12;
    localparam logic [7:0] OP_MULT  = 8'h18;
    localparam logic [7:0] OP_MULTU = 8'h19;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;
    localparam logic [2:0] SEL_ARITH = 3'b100;
    localparam logic [2:0] SEL_MUL   = 3'b101;

    logic [31:0] hi;
    logic [31:0] lo;
    logic        mul_stall;

    logic        is_mul_op;
    logic [31:0] sum;
    logic [31:0] diff;
    logic        add_ovf;
    logic        sub_ovf;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        ovf;

    assign is_mul_op = (aluop_i == OP_MULT) || (aluop_i == OP_MULTU);
    assign sum       = reg1_i + reg2_i;
    assign diff      = reg1_i - reg2_i;
    // Signed overflow: operands agree in sign (add) / differ (sub) and the result sign flips.
    assign add_ovf   = (reg1_i[31] == reg2_i[31]) && (sum[31]  != reg1_i[31]);
    assign sub_ovf   = (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]);
    assign shamt     = reg1_i[4:0];

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (alusel_i)
            SEL_LOGIC: begin
                case (aluop_i)
                    OP_AND:  result = reg1_i & reg2_i;
                    OP_OR:   result = reg1_i | reg2_i;
                    OP_XOR:  result = reg1_i ^ reg2_i;
                    OP_NOR:  result = ~(reg1_i | reg2_i);
                    default: result = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (aluop_i)
                    OP_SLL:  result = reg2_i << shamt;
                    OP_SRL:  result = reg2_i >> shamt;
                    OP_SRA:  result = $signed(reg2_i) >>> shamt;
                    default: result = '0;
                endcase
            end
            SEL_MOVE: begin
                case (aluop_i)
                    OP_MFHI: result = hi;
                    OP_MFLO: result = lo;
                    default: result = '0;
                endcase
            end
            SEL_ARITH: begin
                case (aluop_i)
                    OP_ADD:  begin result = sum;  ovf = add_ovf; end
                    OP_ADDU: result = sum;
                    OP_SUB:  begin result = diff; ovf = sub_ovf; end
                    OP_SUBU: result = diff;
                    OP_SLT:  result = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
                    OP_SLTU: result = {31'd0, reg1_i < reg2_i};
                    default: result = '0;
                endcase
            end
            default: result = '0;   // NOP, MUL (no direct result) and undefined classes
        endcase
    end

`ifdef EX_MULT_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    mul_state_t  state;
    mul_state_t  state_nxt;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic        neg;
    logic        start;
    logic        step;
    logic        commit;
    logic        is_signed;
    logic [31:0] mag1;
    logic [31:0] mag2;

    // Multiply magnitudes; the product sign is reapplied at commit for MULT.
    assign is_signed = (aluop_i == OP_MULT);
    assign mag1      = (is_signed && reg1_i[31]) ? (32'd0 - reg1_i) : reg1_i;
    assign mag2      = (is_signed && reg2_i[31]) ? (32'd0 - reg2_i) : reg2_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                cnt    <= '0;
                acc    <= '0;
                mcand  <= {32'd0, mag1};
                mplier <= mag2;
                neg    <= is_signed && (reg1_i[31] ^ reg2_i[31]);
            end else if (step) begin
                cnt    <= cnt + 5'd1;
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
            if (commit) begin
                {hi, lo} <= neg ? (64'd0 - acc) : acc;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        mul_stall = 1'b0;
        start     = 1'b0;
        step      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (is_mul_op && (alusel_i == SEL_MUL) && !flush_i) begin
                    start     = 1'b1;
                    mul_stall = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_nxt = IDLE;
                end else begin
                    step      = 1'b1;
                    mul_stall = 1'b1;
                    if (cnt == 5'd31) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                commit    = !flush_i;
            end
            default: state_nxt = IDLE;
        endcase
    end
`else
    logic unused_nomul;

    assign hi           = '0;
    assign lo           = '0;
    assign mul_stall    = 1'b0;
    assign unused_nomul = clk ^ flush_i;
`endif

    // Reset forces a quiet write-back port; multiplies and overflowing ADD/SUB never write.
    assign wd_o       = rst ? 5'd0  : wd_i;
    assign wreg_o     = rst ? 1'b0  : (wreg_i && !ovf && !is_mul_op);
    assign wdata_o    = rst ? 32'd0 : result;
    assign ovf_o      = rst ? 1'b0  : ovf;
    assign stallreq_o = rst ? 1'b0  : mul_stall;
    assign hi_o       = hi;
    assign lo_o       = lo;

endmodule
